serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit subtractor controller built around one internal full-subtractor cell.
- Latches two N-bit operands on a start handshake and feeds the cell one bit per clock, LSB first.
- Carries the borrow between bits in a register and assembles the difference.
- Reports difference, borrow-out, signed overflow and zero flags with a one-cycle done pulse.
- Sits between a requesting control FSM and the arithmetic slice.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- bin  input  1  borrow-in; latched on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse when results are valid.
- diff  output  WIDTH  result a - b - bin, modulo 2**WIDTH.
- bout  output  1  final borrow out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow of a - b.
- zero  output  1  diff == 0.

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs go to 0.
  - Operand shift registers, borrow register and counter clear to 0.
  - State goes to IDLE.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded and done does not fire.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a rising edge: latch a, b and bin; counter <= 0; go to RUN.
  - start=0: stay in IDLE.
  - diff, bout, ovf and zero hold their last results.
- RUN, each edge:
  - Cell inputs: x = a_sh[0], y = b_sh[0], c = borrow register.
  - Cell outputs: d = x^y^c; br = (~x&y) | (~(x^y)&c).
  - d shifts into the result register at the MSB (right shift); a_sh and b_sh shift right.
  - borrow register <= br; counter increments.
  - When counter == WIDTH-1 at an edge, that edge processes the final bit and the FSM moves to DONE.
- DONE, for exactly one cycle:
  - done=1.
  - diff = assembled result; bout = final borrow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
  - zero = (diff == 0).
  - The next edge returns the FSM to IDLE.
- Latency: start accepted at edge E0; bits are processed at edges E1..EWIDTH; done is high in the cycle after edge EWIDTH. Accept-to-done is WIDTH cycles, giving a throughput of one operation per WIDTH+2 cycles.
- Result outputs update only on entry to DONE and stay stable until the next DONE.
- busy is registered: it rises the cycle after the accepting edge and falls when the FSM returns to IDLE.
- start while busy=1 (RUN or DONE) is ignored, with no queuing; a/b/bin changes during RUN have no effect.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- WIDTH=1: a single RUN cycle, then DONE.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start for 1 cycle -> done exactly 8 cycles after the accept edge; diff=0x1E, bout=0, ovf=0, zero=0; busy high for 9 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0. a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Pulse start again mid-RUN with different operands -> ignored; the first result completes unchanged and only one done pulse occurs.
- Assert rst at cycle 4 of RUN -> all outputs 0 immediately with no done. Release rst, then run a=0x03, b=0x01 -> diff=0x02.
- Exhaustive sweep with WIDTH=4, all a, b and bin combinations -> diff, bout and ovf match a reference model.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial N-bit subtractor controller around a single full-subtractor cell
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
    logic [CNT_W-1:0] cnt;
    logic brw, x, y, d, br, last, accept;
    // full-subtractor cell on the current LSBs; the new bit enters the result at the MSB
    always_comb begin
        x = a_sh[0];
        y = b_sh[0];
        d = x ^ y ^ brw;
        br = (~x & y) | (~(x ^ y) & brw);
        res_nx = WIDTH'({d, res_sh} >> 1);
        last = (cnt == CNT_W'(WIDTH - 1));
        accept = (state == IDLE) && start;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // next state: IDLE waits for start, RUN walks the bits, DONE lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    // operand latch, serial shifting and result capture on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nx != IDLE);
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                brw    <= bin;
                res_sh <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_nx;
                brw    <= br;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    done <= 1'b1;
                    diff <= res_nx;
                    bout <= br;
                    ovf  <= (x != y) && (d != x);
                    zero <= (res_nx == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: randomized and directed checks of serial_sub_ctrl at WIDTH 8 and 4
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0, bin8 = 1'b0, start4 = 1'b0, bin4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic busy8, done8, bout8, ovf8, zero8;
    logic busy4, done4, bout4, ovf4, zero4;
    logic sel4 = 1'b0;
    logic o_busy, o_done, o_bout, o_ovf, o_zero;
    logic [7:0] o_diff;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    serial_sub_ctrl #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4)
    );

    always_comb begin
        o_busy = sel4 ? busy4 : busy8;
        o_done = sel4 ? done4 : done8;
        o_diff = sel4 ? {4'b0, diff4} : diff8;
        o_bout = sel4 ? bout4 : bout8;
        o_ovf  = sel4 ? ovf4 : ovf8;
        o_zero = sel4 ? zero4 : zero8;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // arithmetic reference: difference modulo 2**w, unsigned borrow, signed overflow of a-b
    task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         output logic [7:0] ed, output logic eb, output logic eo, output logic ez);
        int full;
        full = int'(av) - int'(bv) - int'(bi);
        ed = 8'(full & ((1 << w) - 1));
        eb = int'(av) < int'(bv) + int'(bi);
        eo = (av[w-1] != bv[w-1]) && (ed[w-1] != av[w-1]);
        ez = (ed == 8'h00);
    endtask

    task automatic drive(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic bi);
        if (sel4) begin
            start4 = s; a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi;
        end else begin
            start8 = s; a8 = av; b8 = bv; bin8 = bi;
        end
    endtask

    // one full operation; inj>0 pulses a competing start at that RUN cycle
    task automatic op(input logic w4, input logic [7:0] av, input logic [7:0] bv, input logic bi, input int inj);
        int w, k, nb, nd;
        logic [7:0] ed;
        logic eb, eo, ez;
        sel4 = w4;
        w = w4 ? 4 : 8;
        model(w, av, bv, bi, ed, eb, eo, ez);
        @(negedge clk);
        drive(1'b1, av, bv, bi);
        @(negedge clk);
        drive(1'b0, av, bv, bi);
        nb = 0;
        for (k = 1; k < 40 && !o_done; k++) begin
            if (o_busy) nb++;
            if (inj > 0 && k == inj) drive(1'b1, ~av, bv ^ 8'h55, ~bi);
            else if (inj > 0 && k == inj + 1) drive(1'b0, av, bv, bi);
            @(negedge clk);
        end
        if (k >= 40) begin
            chk("done_timeout", 32'(k), 32'(w + 1));
            return;
        end
        if (o_busy) nb++;
        chk("latency", 32'(k - 1), 32'(w));
        chk("diff", 32'(o_diff), 32'(ed));
        chk("bout", 32'(o_bout), 32'(eb));
        chk("ovf", 32'(o_ovf), 32'(eo));
        chk("zero", 32'(o_zero), 32'(ez));
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'(0));
        chk("busy_cycles", 32'(nb + int'(o_busy)), 32'(w + 1));
        nd = 0;
        for (int i = 0; i < (inj > 0 ? w + 3 : 1); i++) begin
            @(negedge clk);
            if (o_done) nd++;
        end
        chk("extra_done", 32'(nd), 32'(0));
        chk("diff_hold", 32'(o_diff), 32'(ed));
    endtask

    task automatic chk_zero_out(input string tag);
        chk({tag, "_busy"}, 32'(busy8), 32'(0));
        chk({tag, "_done"}, 32'(done8), 32'(0));
        chk({tag, "_diff"}, 32'(diff8), 32'(0));
        chk({tag, "_flags"}, {29'b0, bout8, ovf8, zero8}, 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] dir [6];
        int t1, t2, nd;
        dir = '{{8'h5A, 8'h3C, 1'b0}, {8'h00, 8'h01, 1'b0}, {8'h80, 8'h01, 1'b0},
                {8'h7F, 8'hFF, 1'b0}, {8'h10, 8'h0F, 1'b1}, {8'h00, 8'h00, 1'b1}};
        repeat (3) @(negedge clk);
        chk_zero_out("reset");
        chk("reset_w4", {26'b0, busy4, done4, diff4}, 32'(0));
        rst = 1'b0;

        op(1'b0, 8'h5A, 8'h3C, 1'b0, 0);
        chk("ex_5a_3c", 32'(diff8), 32'h1E);
        for (int i = 1; i < 6; i++) op(1'b0, dir[i][16:9], dir[i][8:1], dir[i][0], 0);
        chk("ex_00_00_bin", {23'b0, bout8, diff8}, 32'h1FF);

        op(1'b0, 8'hC3, 8'h42, 1'b0, 3);

        @(negedge clk);
        drive(1'b1, 8'hA5, 8'h11, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'hA5, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero_out("async_rst");
        nd = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'(0));
        op(1'b0, 8'h03, 8'h01, 1'b0, 0);
        chk("after_rst", 32'(diff8), 32'h02);

        sel4 = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h22, 8'h11, 1'b0);
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 60 && t2 < 0; i++) begin
            @(negedge clk);
            if (done8) begin
                if (t1 < 0) t1 = i; else t2 = i;
            end
        end
        drive(1'b0, 8'h22, 8'h11, 1'b0);
        chk("held_start_spacing", 32'(t2 - t1), 32'(10));
        chk("held_start_diff", 32'(diff8), 32'h11);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 150; i++)
            op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);

        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bi = 0; bi < 2; bi++)
                    op(1'b1, 8'(av), 8'(bv), 1'(bi), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
